// File: rtl/div_if.sv
// Handshake and result bundle for the iterative signed divider.
interface div_if;
    logic        divOP;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] resultHigh;
    logic [31:0] resultLow;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output divOP, A, B,
        input  resultHigh, resultLow, busy, done, div_zero
    );

    modport slave (
        input  divOP, A, B,
        output resultHigh, resultLow, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// 32-bit signed restoring divider, one quotient bit per cycle (MIPS DIV semantics).
// Optional macro DIV_ZERO_DETECT_EN: short-circuits B=0 and raises div_zero.
module div_unit (
    input  logic clk,
    input  logic reset,
    div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
    logic        zero_q, zero_d;
    logic        dz_q, dz_d;
`endif

    logic [32:0] shifted;
    logic [31:0] trial;
    logic        ge;

    // Magnitude wraps for 0x80000000, which is exactly right when read as unsigned.
    function automatic logic [31:0] mag(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        done_d   = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        zero_d   = zero_q;
        dz_d     = dz_q;
`endif

        // {rem, dividend} shifted left; the partial remainder never exceeds 32 bits
        // after subtraction because it was below the divisor before the shift.
        shifted = {rem_q, quo_q[31]};
        ge      = (shifted >= {1'b0, dvs_q});
        trial   = shifted[31:0] - dvs_q;

        case (state_q)
            IDLE: begin
                if (bus.divOP) begin
                    sign_a_d = bus.A[31];
                    sign_b_d = bus.B[31];
                    quo_d    = mag(bus.A);
                    dvs_d    = mag(bus.B);
                    rem_d    = 32'd0;
                    cnt_d    = 5'd0;
                    state_d  = RUN;
`ifdef DIV_ZERO_DETECT_EN
                    dz_d     = 1'b0;
                    zero_d   = (bus.B == 32'd0);
                    if (bus.B == 32'd0) state_d = FINISH;
`endif
                end
            end
            RUN: begin
                rem_d = ge ? trial : shifted[31:0];
                quo_d = {quo_q[30:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FINISH;
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef DIV_ZERO_DETECT_EN
                if (zero_q) begin
                    dz_d = 1'b1;
                end else begin
                    res_lo_d = apply_sign(quo_q, sign_a_q ^ sign_b_q);
                    res_hi_d = apply_sign(rem_q, sign_a_q);
                end
`else
                res_lo_d = apply_sign(quo_q, sign_a_q ^ sign_b_q);
                res_hi_d = apply_sign(rem_q, sign_a_q);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            done_q   <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            zero_q   <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            done_q   <= done_d;
`ifdef DIV_ZERO_DETECT_EN
            zero_q   <= zero_d;
            dz_q     <= dz_d;
`endif
        end
    end

    assign bus.resultHigh = res_hi_q;
    assign bus.resultLow  = res_lo_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != IDLE);
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_zero   = dz_q;
`else
    assign bus.div_zero   = 1'b0;
`endif
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port divOP, input, 1 bit: start request, sampled at the rising edge.
REQ-004 SHALL have port A, input, 32 bits: dividend, signed two's complement.
REQ-005 SHALL have port B, input, 32 bits: divisor, signed two's complement.
REQ-006 SHALL have port resultHigh, output reg, 32 bits: remainder (HI).
REQ-007 SHALL have port resultLow, output reg, 32 bits: quotient (LO).
REQ-008 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port done, output reg, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port div_zero, output reg, 1 bit: divide-by-zero flag; tied 0 when DIV_ZERO_DETECT_EN is undefined.

Function
REQ-011 SHALL have states IDLE, RUN and FINISH; leave IDLE only on divOP=1 at an edge (edge N).
REQ-012 At edge N, SHALL capture |A|, |B|, sign(A) and sign(B); clear the partial remainder and the 5-bit counter; go to RUN.
REQ-013 SHALL compute magnitudes as two's-complement negation when bit 31=1, so |0x80000000| = 0x80000000 as an unsigned 32-bit value.
REQ-014 In RUN, SHALL do one restoring step per edge (N+1..N+32): shift {rem,dividend} left 1; if rem >= |B|, subtract |B| and set quotient bit 1, else 0.
REQ-015 After 32 steps SHALL go to FINISH; at edge N+33, SHALL write resultLow and resultHigh, pulse done=1 for that cycle only, and return to IDLE.
REQ-016 Quotient SHALL be negated iff sign(A) != sign(B); remainder SHALL take the sign of A (truncating division, MIPS DIV semantics).
REQ-017 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000; overflow SHALL NOT be flagged.
REQ-018 busy SHALL be 1 in RUN and FINISH and 0 in IDLE; busy=0 in the cycle done=1.
REQ-019 divOP SHALL be ignored while busy=1; A and B may change after edge N without affecting the result.
REQ-020 divOP=1 in the same cycle as done=1 SHALL start a new division at that edge.
REQ-021 resultHigh and resultLow SHALL hold their values until the next completion or reset.
REQ-022 div_zero SHALL be cleared at every accepted start.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE and set resultHigh, resultLow, done, div_zero, busy, the counter and all internal registers to 0.
REQ-024 Reset SHALL take priority over divOP; reset mid-division SHALL abort it with no done pulse.

Configuration
REQ-025 With DIV_ZERO_DETECT_EN defined, B=0 at start SHALL skip RUN: at edge N+1, set div_zero=1, pulse done, leave resultHigh and resultLow unchanged, and return to IDLE.
REQ-026 Without DIV_ZERO_DETECT_EN, B=0 SHALL run the full 33 cycles; the result is LO = 0xFFFFFFFF for A >= 0 and 0x00000001 for A < 0, HI = A, and div_zero = 0.

Verification
REQ-027 A=7, B=2, divOP at edge N -> at edge N+33, done=1, LO=0x00000003, HI=0x00000001; busy high N+1..N+32.
REQ-028 A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; A=7, B=0xFFFFFFFE -> LO=0xFFFFFFFD, HI=0x00000001.
REQ-029 A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, div_zero=0.
REQ-030 A=100, B=0 -> with macro: done and div_zero at edge N+1, prior results held; without macro: at edge N+33, LO=0xFFFFFFFF, HI=0x00000064.
REQ-031 Start A=100, B=7; assert reset at edge N+10 -> no done pulse, all outputs 0; a new start A=9, B=3 then gives LO=3, HI=0.
REQ-032 divOP pulsed at N+5 during a run -> ignored, result from the first operands; divOP=1 with done -> back-to-back start accepted.
